tile_map_arbiter: RTL
=====================

// Module: tile_map_arbiter
// PURPOSE
//  Owns the single-port tile-map RAM (64x48 tiles of 10x10 px, 640x480@60Hz) and shares it between the
//  display scan-out reader, NUM_WR game-logic writers (tank/bullet update) and a built-in clear sequencer.
//  Display reads have absolute priority; clear sweep next; writers share leftover cycles round-robin.
//  Sits between the VGA timing/pixel path (pixel clock domain) and the game logic.
// PARAMETERS
//  NUM_WR     2     number of writer requesters (1..4)
//  DEPTH      3072  tile-map entries (64*48)
//  ADDR_W     12    tile address width
//  DATA_W     4     tile code width
//  CLEAR_VAL  4'h0  tile code written by clear sweep
// PORTS
//  clk_25m      in   1               pixel clock; only clock
//  rst_n        in   1               reset, synchronous, active-low
//  vblank       in   1               high outside active video rows
//  disp_req     in   1               single-cycle display read request
//  disp_addr    in   ADDR_W          display read address
//  disp_rvalid  out  1               read data valid pulse
//  disp_rdata   out  DATA_W          read data
//  wr_req       in   NUM_WR          per-writer request, held until granted
//  wr_addr      in   NUM_WR*ADDR_W   packed write addresses (writer i at [i*ADDR_W +: ADDR_W])
//  wr_data      in   NUM_WR*DATA_W   packed write data
//  wr_gnt       out  NUM_WR          one-hot grant pulse; write committed that cycle
//  clear_req    in   1               start clear sweep (pulse)
//  clear_busy   out  1               sweep in progress
//  clear_done   out  1               one-cycle pulse after final clear write
//  mem_en/mem_we out 1/1             RAM enable / write enable (registered)
//  mem_addr     out  ADDR_W          RAM address (registered)
//  mem_wdata    out  DATA_W          RAM write data (registered)
//  mem_rdata    in   DATA_W          RAM read data, valid 1 cycle after mem_en&!mem_we
// BEHAVIOUR
//  - Reset (rst_n low at clk_25m edge): all outputs 0, RR pointer 0, FSM IDLE, clear counter 0.
//    Reset mid-sweep aborts it; no clear_done pulse; in-flight read discarded (disp_rvalid stays 0).
//  - Slot decision at cycle t from sampled inputs; mem_* and wr_gnt driven at t+1. Priority:
//    disp_req > clear write (CLEAR state) > writers. Exactly one access per cycle; mem_en=0 if none.
//  - Display read: disp_req at t -> mem_en=1,mem_we=0 at t+1 -> mem_rdata at t+2 ->
//    disp_rvalid=1, disp_rdata registered at t+3. Fixed latency 3; back-to-back reads every cycle allowed.
//  - Writers: round-robin among asserted wr_req; search starts at pointer; after grant to i pointer=(i+1)%NUM_WR.
//    wr_gnt[i] high exactly one cycle, coincident with mem_we. Writer i is masked for the cycle its gnt is high
//    (deasserts req on that edge; no double grant). wr_addr >= DEPTH: granted, mem_en/mem_we held 0 (dropped).
//  - FSM: IDLE -> CLEAR on clear_req; CLEAR writes CLEAR_VAL at addr 0..DEPTH-1, counter advances only on
//    cycles the clear wins the slot; after addr DEPTH-1 written -> IDLE with clear_done at the next cycle.
//    clear_busy=1 for the whole CLEAR state. clear_req while CLEAR ignored. Writers starve during CLEAR.
//  - disp_req and clear/write the same cycle: display wins; loser retries, nothing lost.
// CONFIGURATION
//  VBLANK_ONLY_WR_EN defined: writer grants only when vblank=1 at decision cycle (tear-free updates);
//   clear sweep likewise restricted to vblank. Not defined: writers/clear use any cycle without disp_req.
// STRUCTURE
//  - Shared package tile_map_pkg: DEPTH, ADDR_W, DATA_W, tile codes (TILE_EMPTY, TILE_BRICK, TILE_STEEL,
//    TILE_WATER, TILE_BASE), CLEAR_VAL, FSM state enum {ST_IDLE, ST_CLEAR}.
//  - One sub-module rr_arbiter (NUM_WR req in, one-hot gnt, pointer update enable); rest in top.
//  - Bench uses a behavioural 1-cycle-latency RAM model.
// TESTING
//  1 Reset: rst_n low 3 cycles mid-CLEAR at addr 100 -> all outputs 0, clear_done never pulses, sweep restart on next clear_req from 0.
//  2 Read latency: RAM[5]=4'hA, disp_req addr 5 at t -> mem_en,!mem_we addr 5 at t+1; disp_rvalid,rdata=4'hA at t+3 only.
//  3 RR fairness: wr_req=2'b11 held, re-asserted after each gnt -> grants alternate 0,1,0,1; each gnt single-cycle.
//  4 Collision: disp_req and wr_req[0] same cycle -> read at t+1, wr_gnt[0] at t+2; RAM holds written data.
//  5 Clear: clear_req, disp_req every 10th cycle -> exactly 3072 writes of CLEAR_VAL, clear_done once, busy drop same cycle.
//  6 VBLANK_ONLY_WR_EN: vblank=0 with wr_req[1]=1 -> no gnt; vblank rises at t -> wr_gnt[1] at t+1. Out-of-range addr 3100 -> gnt, no mem_we.

Source files
------------

// File: rtl/tile_map_pkg.sv
// Shared constants, tile codes and types for the tile-map RAM arbiter.
package tile_map_pkg;

    localparam int unsigned DEPTH  = 3072;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 4;

    typedef enum logic [DATA_W-1:0] {
        TILE_EMPTY = 4'h0,
        TILE_BRICK = 4'h1,
        TILE_STEEL = 4'h2,
        TILE_WATER = 4'h3,
        TILE_BASE  = 4'h4
    } tile_e;

    localparam logic [DATA_W-1:0] CLEAR_VAL = DATA_W'(TILE_EMPTY);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    // One RAM access as driven onto the mem_* port.
    typedef struct packed {
        logic              en;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/tile_map_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer, then moves the pointer past it.
module rr_arbiter #(
    parameter int unsigned NUM_WR = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NUM_WR-1:0] req,
    output logic [NUM_WR-1:0] gnt_c
);

    localparam int unsigned PTR_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;

    always_comb begin
        logic found;
        gnt_c = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        // First pass covers [ptr, NUM_WR), second pass wraps to [0, ptr).
        for (int unsigned i = 0; i < NUM_WR; i++) begin
            if (!found && req[i] && (i >= 32'(ptr_q))) begin
                gnt_c[i] = 1'b1;
                ptr_d    = PTR_W'((i + 1) % NUM_WR);
                found    = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NUM_WR; i++) begin
            if (!found && req[i]) begin
                gnt_c[i] = 1'b1;
                ptr_d    = PTR_W'((i + 1) % NUM_WR);
                found    = 1'b1;
            end
        end
        if (!en) begin
            gnt_c = '0;
            ptr_d = ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/tile_map_arbiter.sv
// Single-port tile-map RAM owner: display reads > clear sweep > round-robin writers.
// Build option VBLANK_ONLY_WR_EN restricts writer grants and clear writes to vblank.
module tile_map_arbiter
    import tile_map_pkg::*;
#(
    parameter int unsigned NUM_WR = 2
) (
    input  logic                     clk_25m,
    input  logic                     rst_n,
    input  logic                     vblank,
    input  logic                     disp_req,
    input  logic [ADDR_W-1:0]        disp_addr,
    output logic                     disp_rvalid,
    output logic [DATA_W-1:0]        disp_rdata,
    input  logic [NUM_WR-1:0]        wr_req,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    output logic [NUM_WR-1:0]        wr_gnt,
    input  logic                     clear_req,
    output logic                     clear_busy,
    output logic                     clear_done,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              clr_fin_q, clr_fin_d;
    logic              clear_busy_q, clear_busy_d;
    logic              clear_done_q, clear_done_d;
    mem_req_t          mem_q, mem_d;
    logic [NUM_WR-1:0] wr_gnt_q, wr_gnt_d;
    logic              rd_p1_q, rd_p1_d;
    logic              rd_p2_q, rd_p2_d;
    logic              disp_rvalid_q, disp_rvalid_d;
    logic [DATA_W-1:0] disp_rdata_q, disp_rdata_d;

    logic              bg_ok;
    logic              wr_slot;
    logic [NUM_WR-1:0] arb_gnt_c;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

`ifdef VBLANK_ONLY_WR_EN
    assign bg_ok = vblank;
`else
    logic unused_vblank;
    assign unused_vblank = vblank;
    assign bg_ok         = 1'b1;
`endif

    // Writers only compete for a slot nobody with higher priority wants.
    assign wr_slot = !disp_req && (state_q == ST_IDLE) && bg_ok;

    // A writer still holds req on the edge its grant is seen, so mask it for that cycle.
    rr_arbiter #(.NUM_WR(NUM_WR)) u_rr (
        .clk   (clk_25m),
        .rst_n (rst_n),
        .en    (wr_slot),
        .req   (wr_req & ~wr_gnt_q),
        .gnt_c (arb_gnt_c)
    );

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_WR; i++) begin
            if (arb_gnt_c[i]) begin
                sel_addr = wr_addr[i*ADDR_W +: ADDR_W];
                sel_data = wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_fin_d = 1'b0;
        mem_d     = '0;
        wr_gnt_d  = '0;
        rd_p1_d   = 1'b0;

        if (disp_req) begin
            mem_d.en   = 1'b1;
            mem_d.addr = disp_addr;
            rd_p1_d    = 1'b1;
        end else if ((state_q == ST_CLEAR) && bg_ok) begin
            mem_d.en    = 1'b1;
            mem_d.we    = 1'b1;
            mem_d.addr  = clr_cnt_q;
            mem_d.wdata = CLEAR_VAL;
            if (clr_cnt_q == LAST_ADDR) begin
                clr_cnt_d = '0;
                clr_fin_d = 1'b1;
                state_d   = ST_IDLE;
            end else begin
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            end
        end else if (|arb_gnt_c) begin
            wr_gnt_d = arb_gnt_c;
            // Out-of-range writes are acknowledged but never reach the RAM.
            if (sel_addr < DEPTH_A) begin
                mem_d.en    = 1'b1;
                mem_d.we    = 1'b1;
                mem_d.addr  = sel_addr;
                mem_d.wdata = sel_data;
            end
        end

        if ((state_q == ST_IDLE) && clear_req) state_d = ST_CLEAR;

        // Busy covers the final write; done follows it one cycle later as busy drops.
        clear_busy_d  = (state_d == ST_CLEAR) || clr_fin_d;
        clear_done_d  = clr_fin_q;
        rd_p2_d       = rd_p1_q;
        disp_rvalid_d = rd_p2_q;
        disp_rdata_d  = rd_p2_q ? mem_rdata : disp_rdata_q;
    end

    always_ff @(posedge clk_25m) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            clr_cnt_q     <= '0;
            clr_fin_q     <= 1'b0;
            clear_busy_q  <= 1'b0;
            clear_done_q  <= 1'b0;
            mem_q         <= '0;
            wr_gnt_q      <= '0;
            rd_p1_q       <= 1'b0;
            rd_p2_q       <= 1'b0;
            disp_rvalid_q <= 1'b0;
            disp_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            clr_cnt_q     <= clr_cnt_d;
            clr_fin_q     <= clr_fin_d;
            clear_busy_q  <= clear_busy_d;
            clear_done_q  <= clear_done_d;
            mem_q         <= mem_d;
            wr_gnt_q      <= wr_gnt_d;
            rd_p1_q       <= rd_p1_d;
            rd_p2_q       <= rd_p2_d;
            disp_rvalid_q <= disp_rvalid_d;
            disp_rdata_q  <= disp_rdata_d;
        end
    end

    assign disp_rvalid = disp_rvalid_q;
    assign disp_rdata  = disp_rdata_q;
    assign wr_gnt      = wr_gnt_q;
    assign clear_busy  = clear_busy_q;
    assign clear_done  = clear_done_q;
    assign mem_en      = mem_q.en;
    assign mem_we      = mem_q.we;
    assign mem_addr    = mem_q.addr;
    assign mem_wdata   = mem_q.wdata;

endmodule
